// File: rtl/tcu_drain_pkg.sv
// rtl/tcu_drain_pkg.sv - shared types and FEDP latency helper for the tensor-core drain
package tcu_drain_pkg;

    localparam int XLEN = 32;
    localparam int TAGW = 8;

    typedef logic [TAGW-1:0] tag_t;

    typedef struct packed {
        logic [XLEN-1:0] data;
        tag_t            tag;
    } entry_t;

    // Input stage, multiply, adder tree over 2N products, then normalise/round.
    function automatic int fedp_latency(input int n);
        return 3 + 1 + 3 * $clog2(2 * n) + 3;
    endfunction

endpackage

// File: rtl/tcu_fedp_drain_if.sv
// rtl/tcu_fedp_drain_if.sv - issue and writeback handshakes of the FEDP drain
interface tcu_fedp_drain_if;
    import tcu_drain_pkg::*;

    logic            in_valid;
    logic            in_ready;
    tag_t            in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data;
    tag_t            out_tag;

    modport master (
        output in_valid, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

endinterface

// File: rtl/tcu_drain_fifo.sv
// rtl/tcu_drain_fifo.sv - first-word-fall-through result FIFO for the FEDP drain
module tcu_drain_fifo
    import tcu_drain_pkg::*;
#(
    parameter int DEPTH = 18
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  entry_t                       push_entry,
    input  logic                         pop,
    output entry_t                       head,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    entry_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          full;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage carries no reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign head  = empty ? '0 : mem[rd_ptr];

    a_push_full: assert property (@(posedge clk) disable iff (!reset) !(push && full))
        else $error("result fifo pushed while full");
    a_pop_empty: assert property (@(posedge clk) disable iff (!reset) !(pop && empty))
        else $error("result fifo popped while empty");

endmodule

// File: rtl/tcu_fedp_drain.sv
// rtl/tcu_fedp_drain.sv - credit-gated FEDP issue, tag delay line and result FIFO (perf: TCU_DRAIN_PERF_EN)
module tcu_fedp_drain
    import tcu_drain_pkg::*;
#(
    parameter int LATENCY = 16,
    parameter int DEPTH   = 18
`ifdef TCU_DRAIN_PERF_EN
    ,
    parameter int PERF_W  = 32
`endif
) (
    input  logic               clk,
    input  logic               reset,
    tcu_fedp_drain_if.slave    io,
    output logic               fedp_enable,
    input  logic [XLEN-1:0]    fedp_d_val,
    output logic               idle
`ifdef TCU_DRAIN_PERF_EN
    ,
    output logic [PERF_W-1:0]  perf_issue_stalls,
    output logic [PERF_W-1:0]  perf_out_stalls
`endif
);

    localparam int UW = $clog2(DEPTH + 1);

    logic               fire;
    logic               pop;
    logic               push;
    logic [UW-1:0]      used;
    logic [UW-1:0]      fifo_count;
    logic               fifo_empty;
    entry_t             head;
    entry_t             push_entry;
    logic [LATENCY-1:0] dl_valid;
    tag_t               dl_tag [LATENCY];

    // Admission depends only on the registered credit count, never on out_ready.
    assign io.in_ready = (used < UW'(DEPTH)) & reset;
    assign fedp_enable = reset;
    assign fire        = io.in_valid & io.in_ready;
    assign pop         = io.out_valid & io.out_ready;
    assign push        = dl_valid[LATENCY-1];
    assign push_entry  = '{data: fedp_d_val, tag: dl_tag[LATENCY-1]};
    assign idle        = (used == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            dl_valid <= '0;
        end else begin
            dl_valid <= {dl_valid[LATENCY-2:0], fire};
        end
    end

    always_ff @(posedge clk) begin
        dl_tag[0] <= io.in_tag;
        for (int i = 1; i < LATENCY; i++) begin
            dl_tag[i] <= dl_tag[i-1];
        end
    end

    // A push only moves a credit from the delay line into the FIFO.
    always_ff @(posedge clk) begin
        if (!reset) begin
            used <= '0;
        end else begin
            used <= used + UW'(fire) - UW'(pop);
        end
    end

    tcu_drain_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    assign io.out_valid = !fifo_empty;
    assign io.out_data  = head.data;
    assign io.out_tag   = head.tag;

    a_used_range: assert property (@(posedge clk) disable iff (!reset) used <= UW'(DEPTH))
        else $error("credit count exceeds fifo depth");
    a_fifo_le_used: assert property (@(posedge clk) disable iff (!reset) fifo_count <= used)
        else $error("fifo holds more entries than outstanding credits");

`ifdef TCU_DRAIN_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_issue_stalls <= '0;
            perf_out_stalls   <= '0;
        end else begin
            if (io.in_valid & !io.in_ready)   perf_issue_stalls <= perf_issue_stalls + 1'b1;
            if (io.out_valid & !io.out_ready) perf_out_stalls   <= perf_out_stalls + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_tcu_fedp_drain.sv
// tb/tb_tcu_fedp_drain.sv - scoreboard bench for tcu_fedp_drain with a behavioural FEDP model
module tb_tcu_fedp_drain;
    import tcu_drain_pkg::*;

    localparam int LATENCY = fedp_latency(4);
    localparam int DEPTH   = 18;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            fedp_enable;
    logic [XLEN-1:0] fedp_d_val = '0;
    logic            idle;
`ifdef TCU_DRAIN_PERF_EN
    logic [31:0]     perf_issue_stalls;
    logic [31:0]     perf_out_stalls;
`endif

    always #5 clk = ~clk;

    tcu_fedp_drain_if io ();

    tcu_fedp_drain #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .io                (io.slave),
        .fedp_enable       (fedp_enable),
        .fedp_d_val        (fedp_d_val),
        .idle              (idle)
`ifdef TCU_DRAIN_PERF_EN
        ,
        .perf_issue_stalls (perf_issue_stalls),
        .perf_out_stalls   (perf_out_stalls)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic [7:0]  tag;
        int          push_edge;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] sched [int];
    int          pop_edges[$];
    int          edge_n    = 0;
    bit          rst_edge  = 1'b0;
    int          vectors   = 0;
    int          errors    = 0;
    int          fire_cnt  = 0;
    int          pop_cnt   = 0;
    int          stall_cnt = 0;
    int          m_issue_st = 0;
    int          m_out_st   = 0;
    bit          fixed_en  = 1'b0;
    logic [31:0] fixed_d   = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    always @(posedge clk) begin
        edge_n++;
        rst_edge = !reset;
    end

    // Reference: outstanding issues hold credits until popped; each result
    // becomes visible LATENCY edges after its fire edge, in issue order.
    always @(negedge clk) begin
        bit          exp_rdy;
        bit          exp_ov;
        logic [31:0] d;
        if (!reset) begin
            chk("in_ready_in_reset", io.in_ready, 0);
            chk("fedp_enable_in_reset", fedp_enable, 0);
            if (rst_edge) begin
                chk("out_valid_in_reset", io.out_valid, 0);
                chk("out_data_in_reset", io.out_data, 0);
                chk("out_tag_in_reset", io.out_tag, 0);
                chk("idle_in_reset", idle, 1);
`ifdef TCU_DRAIN_PERF_EN
                chk("perf_issue_in_reset", perf_issue_stalls, 0);
                chk("perf_out_in_reset", perf_out_stalls, 0);
`endif
            end
            exp_q.delete();
            sched.delete();
            m_issue_st = 0;
            m_out_st   = 0;
        end else if (edge_n > 0) begin
            exp_rdy = (exp_q.size() < DEPTH);
            exp_ov  = (exp_q.size() > 0) && (exp_q[0].push_edge <= edge_n);
            chk("in_ready", io.in_ready, exp_rdy);
            chk("fedp_enable", fedp_enable, 1);
            chk("idle", idle, exp_q.size() == 0);
            chk("out_valid", io.out_valid, exp_ov);
`ifdef TCU_DRAIN_PERF_EN
            chk("perf_issue_stalls", perf_issue_stalls, m_issue_st);
            chk("perf_out_stalls", perf_out_stalls, m_out_st);
`endif
            if (io.in_valid && !exp_rdy) begin
                stall_cnt++;
                m_issue_st++;
            end
            if (exp_ov && !io.out_ready) m_out_st++;
            if (exp_ov && io.out_ready) begin
                chk("out_data", io.out_data, exp_q[0].data);
                chk("out_tag", io.out_tag, exp_q[0].tag);
                pop_cnt++;
                pop_edges.push_back(edge_n);
                void'(exp_q.pop_front());
            end
            if (io.in_valid && exp_rdy) begin
                d = fixed_en ? fixed_d : $urandom;
                sched[edge_n + 1 + LATENCY] = d;
                exp_q.push_back('{d, io.in_tag, edge_n + 1 + LATENCY});
                fire_cnt++;
            end
        end
        if (sched.exists(edge_n + 1)) begin
            fedp_d_val = sched[edge_n + 1];
            sched.delete(edge_n + 1);
        end else begin
            fedp_d_val = $urandom;
        end
    end

    task automatic drain();
        bit done;
        done = 1'b0;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (idle && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t0;
        int s0;
        int f0;
        int p0;
        bit seen;

        io.in_valid  = 1'b1;
        io.in_tag    = '0;
        io.out_ready = 1'b0;
        reset        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset       = 1'b1;
        io.in_valid = 1'b0;
        #1;
        chk("in_ready_after_release", io.in_ready, 1);

        // single issue, known result word
        repeat (3) @(posedge clk);
        #1;
        io.in_valid  = 1'b1;
        io.in_tag    = 8'h5A;
        io.out_ready = 1'b1;
        fixed_en     = 1'b1;
        fixed_d      = 32'h3F80_0000;
        t0           = edge_n + 1;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        fixed_en    = 1'b0;
        seen        = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (io.out_valid) seen = 1'b1;
        end
        chk("single_seen", seen, 1);
        chk("single_latency_edges", edge_n - t0, LATENCY);
        chk("single_data", io.out_data, 32'h3F80_0000);
        chk("single_tag", io.out_tag, 8'h5A);
        @(negedge clk);
        chk("single_idle_after_pop", idle, 1);
        drain();

        // streaming, tags 0..63 back-to-back
        pop_edges.delete();
        s0 = stall_cnt;
        for (int i = 0; i < 64; i++) begin
            io.in_valid = 1'b1;
            io.in_tag   = 8'(i);
            @(posedge clk);
            #1;
        end
        drain();
        chk("stream_issue_stalls", stall_cnt - s0, 0);
        chk("stream_pop_count", pop_edges.size(), 64);
        if (pop_edges.size() == 64) chk("stream_gapless", pop_edges[63] - pop_edges[0], 63);

        // backpressure: fill all credits, then hold 30 cycles past full
        f0 = fire_cnt;
        io.out_ready = 1'b0;
        io.in_valid  = 1'b1;
        for (int i = 0; i < DEPTH + 30; i++) begin
            io.in_tag = 8'($urandom);
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", fire_cnt - f0, DEPTH);
        chk("bp_in_ready_low", io.in_ready, 0);
`ifdef TCU_DRAIN_PERF_EN
        chk("bp_perf_issue_30", perf_issue_stalls, 30);
`endif
        f0 = fire_cnt;
        p0 = pop_cnt;
        io.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            io.in_tag = 8'($urandom);
            @(posedge clk);
            #1;
        end
        chk("bp_refill_one_per_pop", fire_cnt - f0, pop_cnt - p0 - 1);
        drain();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            io.in_valid  = $urandom_range(0, 1);
            io.in_tag    = 8'($urandom);
            io.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        drain();

        // reset with 5 issues in flight and 2 results queued
        io.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            io.in_valid = 1'b1;
            io.in_tag   = 8'(8'hA0 + i);
            @(posedge clk);
            #1;
        end
        io.in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (io.out_valid) seen = 1'b1;
        end
        chk("mid_first_visible", seen, 1);
        @(posedge clk);
        #1;
        chk("mid_outstanding", exp_q.size(), 7);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset        = 1'b1;
        io.out_ready = 1'b1;
        chk("mid_idle_after_reset", idle, 1);
        p0 = pop_cnt;
        repeat (40) @(negedge clk);
        chk("mid_no_results", pop_cnt - p0, 0);
        chk("mid_out_valid", io.out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
